// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//
// Merges two writeback sources onto the single register-file write port.
// Port A (primary pipeline) always wins and lands one cycle later. Port B
// (long-latency units) is buffered in a small FIFO and drains into the
// cycles port A leaves idle. A 32-bit scoreboard tracks registers that have
// an outstanding port-B write, so the issue logic can stall on hazards.
//
// Ports
//   clk, rst_n                clock, synchronous active-low reset
//   a_valid, a_rd, a_data     port-A write request (always accepted)
//   b_valid, b_ready          port-B handshake into the FIFO
//   b_rd, b_data              port-B write payload
//   issue_valid, issue_rd     marks issue_rd as pending a port-B write
//   we, rw_i, rw_data_i       registered register-file write port
//   busy_o                    scoreboard, bit r = port-B write to r pending
//   count_o                   FIFO occupancy
// ---------------------------------------------------------------------------
module regfile_writeback #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          a_valid,
    input  logic [4:0]                    a_rd,
    input  logic [31:0]                   a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [4:0]                    b_rd,
    input  logic [31:0]                   b_data,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    output logic                          we,
    output logic [4:0]                    rw_i,
    output logic [31:0]                   rw_data_i,
    output logic [31:0]                   busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage: {rd, data}
    logic [36:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          we_q, we_d;
    logic [4:0]    rw_q, rw_d;
    logic [31:0]   rw_data_q, rw_data_d;
    logic [31:1]   busy_q;

    logic          a_take;
    logic          push;
    logic          pop;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    // Ready depends only on registered occupancy, so a same-cycle pop never
    // opens a slot for a push when full.
    assign b_ready   = (count_q != CW'(FIFO_DEPTH));
    assign push      = b_valid && b_ready;
    assign a_take    = a_valid && (a_rd != 5'd0);
    // The head is read from registered storage only; an entry pushed this
    // edge is not visible until the next one, so there is no b_* bypass.
    assign pop       = !a_take && (count_q != '0);
    assign head_rd   = mem_q[head_q][36:32];
    assign head_data = mem_q[head_q][31:0];

    always_comb begin
        we_d      = 1'b0;
        rw_d      = rw_q;
        rw_data_d = rw_data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (a_take) begin
            we_d      = 1'b1;
            rw_d      = a_rd;
            rw_data_d = a_data;
        end else if (pop) begin
            // An rd=0 entry still uses its slot but produces no write.
            if (head_rd != 5'd0) begin
                we_d      = 1'b1;
                rw_d      = head_rd;
                rw_data_d = head_data;
            end
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            rw_q      <= 5'd0;
            rw_data_q <= 32'd0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            we_q      <= we_d;
            rw_q      <= rw_d;
            rw_data_q <= rw_data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= {b_rd, b_data};
        end
    end

    // Scoreboard, one flop per architectural register (r0 never pending).
    // Set is applied after clear so a same-edge issue keeps the bit high.
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = issue_valid && (issue_rd == 5'(gi));
            assign clr_bit = pop && (head_rd == 5'(gi));
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    busy_q[gi] <= 1'b0;
                end else if (set_bit) begin
                    busy_q[gi] <= 1'b1;
                end else if (clr_bit) begin
                    busy_q[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign we        = we_q;
    assign rw_i      = rw_q;
    assign rw_data_i = rw_data_q;
    assign busy_o    = {busy_q, 1'b0};
    assign count_o   = count_q;

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001: Module SHALL have parameter FIFO_DEPTH, default 4, giving the number of entries in the port-B writeback queue; legal values are powers of two, 2..16.
REQ-002: clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003: rst_n  input  1  reset, synchronous, active-low.
REQ-004: a_valid  input  1  primary-pipeline writeback request; always accepted, no ready signal.
REQ-005: a_rd  input  5  destination register for the port-A write.
REQ-006: a_data  input  32  write data for port A.
REQ-007: b_valid  input  1  long-latency-unit writeback request, for example divider results or load misses.
REQ-008: b_ready  output  1  queue can accept a port-B request.
REQ-009: b_rd  input  5  destination register for the port-B write.
REQ-010: b_data  input  32  write data for port B.
REQ-011: issue_valid  input  1  a long-latency operation has issued and will later write issue_rd through port B.
REQ-012: issue_rd  input  5  destination register to mark pending.
REQ-013: we  output  1  register-file write enable, registered.
REQ-014: rw_i  output  5  register-file write address, registered.
REQ-015: rw_data_i  output  32  register-file write data, registered.
REQ-016: busy_o  output  32  scoreboard; bit r set means a port-B write to register r is outstanding.
REQ-017: count_o  output  clog2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-018: Port-B request SHALL be pushed to the queue tail on an edge where b_valid and b_ready are both 1; b_ready SHALL equal (count_o != FIFO_DEPTH), computed from registered occupancy only.
REQ-019: When full, b_ready SHALL be 0 even if a pop occurs in the same cycle; a stalled source holds b_rd/b_data until accepted.
REQ-020: Write-port arbitration at each edge: port A SHALL have priority; if a_valid=1 and a_rd!=0, the next-cycle outputs SHALL be we=1, rw_i=a_rd, rw_data_i=a_data, and the queue SHALL NOT pop.
REQ-021: Otherwise, if the queue is non-empty, the head SHALL be popped and the next-cycle outputs SHALL be we=1, rw_i=head rd, rw_data_i=head data.
REQ-022: Otherwise the next-cycle output SHALL be we=0; rw_i and rw_data_i SHALL hold their last values.
REQ-023: Port-A latency SHALL be exactly 1 cycle; a port-B entry pushed at edge N SHALL be poppable at the earliest at edge N+1, giving we at N+1; there SHALL be no bypass path from b_* to the outputs.
REQ-024: Writes to rd=0 from either port SHALL be accepted and discarded: no we pulse, and a port-B rd=0 entry SHALL consume its pop slot with we=0.
REQ-025: Simultaneous push and pop SHALL leave count_o unchanged; head/tail pointers SHALL wrap modulo FIFO_DEPTH; the queue SHALL preserve FIFO order.
REQ-026: Scoreboard: issue_valid=1 with issue_rd!=0 SHALL set busy_o[issue_rd] at the edge.
REQ-027: A pop for register r SHALL clear busy_o[r] at the same edge.
REQ-028: If a set and a clear target the same bit at the same edge, set SHALL win.
REQ-029: busy_o[0] SHALL be constant 0.
REQ-030: Ordering hazards between port A and outstanding port-B writes to the same register are the consumer's responsibility via busy_o; this block SHALL NOT reorder or merge writes.

Reset
REQ-031: While rst_n=0 at an edge: we=0, rw_i=0, rw_data_i=0, busy_o=0, count_o=0, pointers=0, b_ready=1 from the following cycle.
REQ-032: Reset asserted mid-operation SHALL discard all queued entries without issuing writes, and SHALL ignore a_valid, b_valid and issue_valid sampled at that edge.

Verification
REQ-033: Port-A priority: a_valid=1, a_rd=5, a_data=0x11 for one cycle while the queue holds {rd=7, 0x22} -> we=1, rw_i=5, data 0x11 next cycle; then rw_i=7, data 0x22 the cycle after; count_o goes 1 then 0.
REQ-034: Fill/backpressure: push 4 port-B writes (rd 1..4) with a_valid held 1, a_rd=8 -> count_o=4, b_ready=0, and a 5th request is held; release a_valid -> writes drain rd 1,2,3,4 in order, one per cycle, b_ready=1 after the first pop, and the held 5th entry is accepted.
REQ-035: rd=0 discard: a_valid with a_rd=0, and a port-B entry with rd=0 -> we stays 0, entry popped, count_o decrements.
REQ-036: Scoreboard: issue rd=9 -> busy_o[9]=1; port-B write to rd 9 popped -> busy_o[9]=0 at the same edge that we=1; issue rd=9 at the same edge as the pop -> busy_o[9] stays 1.
REQ-037: Reset mid-drain with 3 queued entries -> next cycle we=0, count_o=0, busy_o=0, b_ready=1, and no further writes are issued.
